// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester, ALU and response signals for alu_share_arbiter.
// slave: the arbiter's view. master: the surrounding logic's view.
interface alu_share_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic [5:0]        req0_funct;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic              req1_valid;
    logic              req1_ready;
    logic [5:0]        req1_funct;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [2:0]        alu_sel;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_res;
    logic              alu_zero;
    logic              alu_ovf;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_res;
    logic              rsp_zero;
    logic              rsp_ovf;
    logic              rsp_err;
    logic              busy;

    modport slave (
        input  req0_valid, req0_funct, req0_a, req0_b,
        input  req1_valid, req1_funct, req1_a, req1_b,
        input  alu_res, alu_zero, alu_ovf, rsp_ready,
        output req0_ready, req1_ready, alu_sel, alu_a, alu_b,
        output rsp_valid, rsp_id, rsp_res, rsp_zero, rsp_ovf, rsp_err, busy
    );

    modport master (
        output req0_valid, req0_funct, req0_a, req0_b,
        output req1_valid, req1_funct, req1_a, req1_b,
        output alu_res, alu_zero, alu_ovf, rsp_ready,
        input  req0_ready, req1_ready, alu_sel, alu_a, alu_b,
        input  rsp_valid, rsp_id, rsp_res, rsp_zero, rsp_ovf, rsp_err, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external combinational 32-bit ALU between two
// R-type requesters. Decodes MIPS funct, drives the ALU for one cycle from
// registered operands, and returns the captured result over valid/ready.
// Optional macro ALU_SHARE_ARBITER_STATS_EN adds per-requester completion
// and illegal-op counters; without it stat_* are tied to zero.
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_share_arbiter_if.slave bus,
    output logic [STAT_W-1:0] stat_cnt0,
    output logic [STAT_W-1:0] stat_cnt1,
    output logic [STAT_W-1:0] stat_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]               state;
    logic                     rr_ptr;
    logic                     gnt_vld;
    logic                     gnt_id;
    logic [5:0]               gnt_funct;
    logic signed [DATA_W-1:0] gnt_a;
    logic signed [DATA_W-1:0] gnt_b;
    logic [3:0]               gnt_dec;
    logic [2:0]               sel_p0;
    logic signed [DATA_W-1:0] a_p0;
    logic signed [DATA_W-1:0] b_p0;
    logic                     ovf_fix;

    // {legal, alu_sel} for a MIPS R-type funct
    function automatic logic [3:0] decode_funct(input logic [5:0] funct);
        case (funct)
            6'h24:   return 4'b1_000;
            6'h25:   return 4'b1_001;
            6'h20:   return 4'b1_010;
            6'h26:   return 4'b1_011;
            6'h22:   return 4'b1_100;
            6'h02:   return 4'b1_101;
            6'h00:   return 4'b1_110;
            6'h27:   return 4'b1_111;
            default: return 4'b0_000;
        endcase
    endfunction

    // Two's-complement overflow of a - b, judged from the operand and result signs
    function automatic logic sub_ovf(input logic signed [DATA_W-1:0] a,
                                     input logic signed [DATA_W-1:0] b,
                                     input logic signed [DATA_W-1:0] r);
        return (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
    endfunction

    // Grant selection: only from IDLE, round-robin on a tie, never during reset
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (rst_n && state == IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                gnt_vld = 1'b1;
                gnt_id  = rr_ptr;
            end else if (bus.req0_valid) begin
                gnt_vld = 1'b1;
            end else if (bus.req1_valid) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b1;
            end
        end
        gnt_funct = gnt_id ? bus.req1_funct : bus.req0_funct;
        gnt_a     = gnt_id ? bus.req1_a     : bus.req0_a;
        gnt_b     = gnt_id ? bus.req1_b     : bus.req0_b;
        gnt_dec   = decode_funct(gnt_funct);
    end

    assign bus.req0_ready = gnt_vld && !gnt_id;
    assign bus.req1_ready = gnt_vld && gnt_id;

    // The ALU only sees operands during EXEC; otherwise it is held at zero
    assign bus.alu_sel   = (state == EXEC) ? sel_p0 : 3'b000;
    assign bus.alu_a     = (state == EXEC) ? a_p0   : '0;
    assign bus.alu_b     = (state == EXEC) ? b_p0   : '0;
    assign bus.rsp_valid = (state == RESP);
    assign bus.busy      = (state != IDLE);

    // Overflow: ADD trusts the ALU flag, SUB is recomputed locally, rest never overflow
    always_comb begin
        ovf_fix = 1'b0;
        case (sel_p0)
            3'b010:  ovf_fix = bus.alu_ovf;
            3'b100:  ovf_fix = sub_ovf(a_p0, b_p0, bus.alu_res);
            default: ovf_fix = 1'b0;
        endcase
    end

    // Operand capture at grant; data only, no reset needed
    always_ff @(posedge clk) begin
        if (gnt_vld) begin
            sel_p0 <= gnt_dec[2:0];
            a_p0   <= gnt_a;
            b_p0   <= gnt_b;
        end
    end

    // Control FSM and response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= 1'b0;
            bus.rsp_id   <= 1'b0;
            bus.rsp_res  <= '0;
            bus.rsp_zero <= 1'b0;
            bus.rsp_ovf  <= 1'b0;
            bus.rsp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        rr_ptr     <= ~gnt_id;
                        bus.rsp_id <= gnt_id;
                        if (gnt_dec[3]) begin
                            state <= EXEC;
                        end else begin
                            state        <= RESP;
                            bus.rsp_err  <= 1'b1;
                            bus.rsp_res  <= '0;
                            bus.rsp_zero <= 1'b0;
                            bus.rsp_ovf  <= 1'b0;
                        end
                    end
                end
                EXEC: begin
                    bus.rsp_res  <= bus.alu_res;
                    bus.rsp_zero <= bus.alu_zero;
                    bus.rsp_ovf  <= ovf_fix;
                    bus.rsp_err  <= 1'b0;
                    state        <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_SHARE_ARBITER_STATS_EN
    logic hs;
    assign hs = (state == RESP) && bus.rsp_ready;

    // Count completed responses per requester and illegal ops, wrapping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_cnt0 <= '0;
            stat_cnt1 <= '0;
            stat_err  <= '0;
        end else if (hs) begin
            if (bus.rsp_err) begin
                stat_err <= stat_err + 1'b1;
            end else if (bus.rsp_id) begin
                stat_cnt1 <= stat_cnt1 + 1'b1;
            end else begin
                stat_cnt0 <= stat_cnt0 + 1'b1;
            end
        end
    end
`else
    assign stat_cnt0 = '0;
    assign stat_cnt1 = '0;
    assign stat_err  = '0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed vector table, directed
// multi-cycle sequences, and random traffic against a behavioural model.
module tb_alu_share_arbiter;

    localparam int STAT_W = 16;
`ifdef ALU_SHARE_ARBITER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic [STAT_W-1:0] stat_cnt0, stat_cnt1, stat_err;
    int n_chk;
    int n_fail;

    alu_share_arbiter_if #(.DATA_W(32)) bus ();

    alu_share_arbiter #(.DATA_W(32), .STAT_W(STAT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .stat_cnt0 (stat_cnt0),
        .stat_cnt1 (stat_cnt1),
        .stat_err  (stat_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU; overflow follows the add rule regardless of operation
    logic [31:0] alu_r;
    always_comb begin
        alu_r = '0;
        case (bus.alu_sel)
            3'd0: alu_r = bus.alu_a & bus.alu_b;
            3'd1: alu_r = bus.alu_a | bus.alu_b;
            3'd2: alu_r = bus.alu_a + bus.alu_b;
            3'd3: alu_r = bus.alu_a ^ bus.alu_b;
            3'd4: alu_r = bus.alu_a - bus.alu_b;
            3'd5: alu_r = bus.alu_a >> bus.alu_b[4:0];
            3'd6: alu_r = bus.alu_a << bus.alu_b[4:0];
            default: alu_r = ~(bus.alu_a | bus.alu_b);
        endcase
    end
    assign bus.alu_res  = alu_r;
    assign bus.alu_zero = (alu_r == 32'd0);
    assign bus.alu_ovf  = (bus.alu_a[31] == bus.alu_b[31]) && (alu_r[31] != bus.alu_a[31]);

    typedef struct {
        logic        id;
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic        err;
        logic [2:0]  sel;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input logic id, input logic vld, input logic [5:0] f,
                           input logic [31:0] a, input logic [31:0] b);
        if (id) begin
            bus.req1_valid = vld; bus.req1_funct = f; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = vld; bus.req0_funct = f; bus.req0_a = a; bus.req0_b = b;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference: result of an R-type op computed directly from funct with wide arithmetic
    function automatic void ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                   output logic err, output logic [31:0] res, output logic zero,
                                   output logic ovf, output logic [2:0] sel);
        longint sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s = 0;
        err = 1'b0; ovf = 1'b0; sel = 3'd0; res = '0;
        case (f)
            6'h24: begin sel = 3'd0; res = a & b; end
            6'h25: begin sel = 3'd1; res = a | b; end
            6'h20: begin sel = 3'd2; s = sa + sb; res = s[31:0];
                         ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            6'h26: begin sel = 3'd3; res = a ^ b; end
            6'h22: begin sel = 3'd4; s = sa - sb; res = s[31:0];
                         ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            6'h02: begin sel = 3'd5; res = a >> b[4:0]; end
            6'h00: begin sel = 3'd6; res = a << b[4:0]; end
            6'h27: begin sel = 3'd7; res = ~(a | b); end
            default: err = 1'b1;
        endcase
        zero = !err && (res == 32'd0);
    endfunction

    // One isolated op from an idle arbiter with rsp_ready held high
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        set_req(v.id, 1'b1, v.funct, v.a, v.b);
        bus.rsp_ready = 1'b1;
        #1;
        chk("vec_gnt", v.id ? bus.req1_ready : bus.req0_ready, 1);
        chk("vec_other_rdy", v.id ? bus.req0_ready : bus.req1_ready, 0);
        @(negedge clk);
        set_req(v.id, 1'b0, 6'h0, 32'h0, 32'h0);
        #1;
        if (!v.err) begin
            chk("vec_exec_vld", bus.rsp_valid, 0);
            chk("vec_alu_sel", bus.alu_sel, v.sel);
            chk("vec_alu_a", bus.alu_a, v.a);
            chk("vec_alu_b", bus.alu_b, v.b);
            @(negedge clk);
            #1;
        end else begin
            chk("vec_ill_sel", bus.alu_sel, 0);
        end
        chk("vec_rsp_vld", bus.rsp_valid, 1);
        chk("vec_rsp_id", bus.rsp_id, v.id);
        chk("vec_rsp_res", bus.rsp_res, v.res);
        chk("vec_rsp_zero", bus.rsp_zero, v.zero);
        chk("vec_rsp_ovf", bus.rsp_ovf, v.ovf);
        chk("vec_rsp_err", bus.rsp_err, v.err);
        @(negedge clk);
        #1;
        chk("vec_after_vld", bus.rsp_valid, 0);
        chk("vec_after_busy", bus.busy, 0);
    endtask

    // Random-test state
    logic        p_vld [2];
    logic [5:0]  p_f   [2];
    logic [31:0] p_a   [2];
    logic [31:0] p_b   [2];
    logic [5:0]  legal_f [8];
    logic [31:0] special [4];

    initial begin
        bit m_busy;
        int m_exec_cyc, m_rsp_cyc, last, g;
        int m_cnt0, m_cnt1, m_cnte;
        logic e_id, e_err, e_zero, e_ovf, exp_vld, exp_exec;
        logic [31:0] e_res, e_a, e_b;
        logic [2:0] e_sel;

        n_chk = 0;
        n_fail = 0;
        vecs[0]  = '{1'b0, 6'h20, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b1, 1'b0, 3'd2};
        vecs[1]  = '{1'b1, 6'h22, 32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 3'd4};
        vecs[2]  = '{1'b1, 6'h22, 32'h5,        32'h5,        32'h0,        1'b1, 1'b0, 1'b0, 3'd4};
        vecs[3]  = '{1'b0, 6'h24, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[4]  = '{1'b1, 6'h25, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0, 1'b0, 1'b0, 3'd1};
        vecs[5]  = '{1'b0, 6'h26, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1'b0, 1'b0, 1'b0, 3'd3};
        vecs[6]  = '{1'b1, 6'h27, 32'hF0F0F0F0, 32'h0F0F0000, 32'h00000F0F, 1'b0, 1'b0, 1'b0, 3'd7};
        vecs[7]  = '{1'b0, 6'h00, 32'h1,        32'h4,        32'h10,       1'b0, 1'b0, 1'b0, 3'd6};
        vecs[8]  = '{1'b1, 6'h02, 32'h80000000, 32'd31,       32'h1,        1'b0, 1'b0, 1'b0, 3'd5};
        vecs[9]  = '{1'b0, 6'h20, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0, 1'b0, 3'd2};
        vecs[10] = '{1'b1, 6'h22, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, 1'b0, 3'd4};
        vecs[11] = '{1'b0, 6'h3F, 32'h12345678, 32'h9,        32'h0,        1'b0, 1'b0, 1'b1, 3'd0};
        vecs[12] = '{1'b0, 6'h20, 32'h80000000, 32'h80000000, 32'h0,        1'b1, 1'b1, 1'b0, 3'd2};
        vecs[13] = '{1'b1, 6'h22, 32'h0,        32'h80000000, 32'h80000000, 1'b0, 1'b1, 1'b0, 3'd4};
        vecs[14] = '{1'b1, 6'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 1'b1, 3'd0};
        vecs[15] = '{1'b0, 6'h22, 32'h80000000, 32'h80000000, 32'h0,        1'b1, 1'b0, 1'b0, 3'd4};
        vecs[16] = '{1'b1, 6'h26, 32'h80000000, 32'h80000000, 32'h0,        1'b1, 1'b0, 1'b0, 3'd3};
        legal_f = '{6'h24, 6'h25, 6'h20, 6'h26, 6'h22, 6'h02, 6'h00, 6'h27};
        special = '{32'h0, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};

        // Reset state, with both requesters asserting valid during reset
        rst_n = 1'b0;
        bus.rsp_ready = 1'b0;
        set_req(1'b0, 1'b1, 6'h24, 32'h1, 32'h1);
        set_req(1'b1, 1'b1, 6'h24, 32'h2, 32'h2);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rdy0", bus.req0_ready, 0);
        chk("rst_rdy1", bus.req1_ready, 0);
        chk("rst_rsp_vld", bus.rsp_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_alu_sel", bus.alu_sel, 0);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_rsp_res", bus.rsp_res, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_stat", {stat_cnt0, stat_cnt1, stat_err}, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_rr_first", {bus.req1_ready, bus.req0_ready}, 2'b01);
        do_reset();

        // Table vectors
        for (int i = 0; i < 17; i++) run_vec(vecs[i]);

        // Illegal op and counters
        do_reset();
        run_vec(vecs[11]);
        chk("stat_err_ill", stat_err, STATS ? 1 : 0);
        chk("stat_cnt0_ill", stat_cnt0, 0);
        run_vec(vecs[0]);
        chk("stat_cnt0_add", stat_cnt0, STATS ? 1 : 0);
        chk("stat_cnt1_add", stat_cnt1, 0);

        // Round robin with both requesters continuously valid
        do_reset();
        @(negedge clk);
        set_req(1'b0, 1'b1, 6'h24, 32'hFF00FF00, 32'h0FF00FF0);
        set_req(1'b1, 1'b1, 6'h24, 32'h12345678, 32'hFFFF0000);
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            chk("rr_rdy0", bus.req0_ready, (k % 3 == 0) && ((k / 3) % 2 == 0));
            chk("rr_rdy1", bus.req1_ready, (k % 3 == 0) && ((k / 3) % 2 == 1));
            chk("rr_rsp_vld", bus.rsp_valid, k % 3 == 2);
            if (k % 3 == 2) begin
                chk("rr_rsp_id", bus.rsp_id, (k / 3) % 2);
                chk("rr_rsp_res", bus.rsp_res, ((k / 3) % 2) ? 32'h12340000 : 32'h0F000F00);
            end
            @(negedge clk);
        end

        // Backpressure: response held while req1 waits
        do_reset();
        @(negedge clk);
        set_req(1'b0, 1'b1, 6'h20, 32'd3, 32'd4);
        set_req(1'b1, 1'b1, 6'h24, 32'hFFFF, 32'hFF);
        bus.rsp_ready = 1'b0;
        #1;
        chk("bp_gnt0", bus.req0_ready, 1);
        @(negedge clk);
        set_req(1'b0, 1'b0, 6'h0, 32'h0, 32'h0);
        #1;
        chk("bp_exec_rdy1", bus.req1_ready, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk("bp_vld", bus.rsp_valid, 1);
            chk("bp_res", bus.rsp_res, 32'd7);
            chk("bp_id", bus.rsp_id, 0);
            chk("bp_rdy1", bus.req1_ready, 0);
            chk("bp_busy", bus.busy, 1);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_hs_vld", bus.rsp_valid, 1);
        chk("bp_hs_rdy1", bus.req1_ready, 0);
        @(negedge clk);
        #1;
        chk("bp_idle_vld", bus.rsp_valid, 0);
        chk("bp_idle_busy", bus.busy, 0);
        chk("bp_idle_rdy1", bus.req1_ready, 1);

        // Reset during EXEC drops the op and restores rr_ptr
        do_reset();
        @(negedge clk);
        set_req(1'b0, 1'b1, 6'h20, 32'd1, 32'd2);
        bus.rsp_ready = 1'b1;
        #1;
        chk("mr_gnt0", bus.req0_ready, 1);
        @(negedge clk);
        set_req(1'b0, 1'b0, 6'h0, 32'h0, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("mr_exec_busy", bus.busy, 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mr_busy", bus.busy, 0);
        chk("mr_vld", bus.rsp_valid, 0);
        chk("mr_alu_sel", bus.alu_sel, 0);
        chk("mr_alu_a", bus.alu_a, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("mr_no_rsp", bus.rsp_valid, 0);
        end
        @(negedge clk);
        set_req(1'b0, 1'b1, 6'h24, 32'h1, 32'h1);
        set_req(1'b1, 1'b1, 6'h24, 32'h1, 32'h1);
        #1;
        chk("mr_rr0", {bus.req1_ready, bus.req0_ready}, 2'b01);

        // Random traffic against the behavioural model
        do_reset();
        m_busy = 1'b0; last = 1; m_exec_cyc = 0; m_rsp_cyc = 0;
        m_cnt0 = 0; m_cnt1 = 0; m_cnte = 0;
        e_id = 1'b0; e_err = 1'b0; e_zero = 1'b0; e_ovf = 1'b0;
        e_res = '0; e_a = '0; e_b = '0; e_sel = '0;
        for (int i = 0; i < 2; i++) p_vld[i] = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!p_vld[i] && ($urandom % 3 == 0)) begin
                    p_vld[i] = 1'b1;
                    p_f[i] = ($urandom % 10 < 8) ? legal_f[$urandom % 8] : 6'($urandom % 64);
                    p_a[i] = ($urandom % 4 == 0) ? special[$urandom % 4] : $urandom;
                    p_b[i] = ($urandom % 4 == 0) ? special[$urandom % 4] : $urandom;
                end
                set_req(i[0], p_vld[i], p_f[i], p_a[i], p_b[i]);
            end
            bus.rsp_ready = ($urandom % 4 != 0);
            #1;
            g = -1;
            if (!m_busy) begin
                if (p_vld[0] && p_vld[1]) g = 1 - last;
                else if (p_vld[0]) g = 0;
                else if (p_vld[1]) g = 1;
            end
            chk("rnd_rdy0", bus.req0_ready, g == 0);
            chk("rnd_rdy1", bus.req1_ready, g == 1);
            chk("rnd_busy", bus.busy, m_busy);
            exp_vld = m_busy && (cyc >= m_rsp_cyc);
            chk("rnd_rsp_vld", bus.rsp_valid, exp_vld);
            if (exp_vld) begin
                chk("rnd_rsp_id", bus.rsp_id, e_id);
                chk("rnd_rsp_res", bus.rsp_res, e_res);
                chk("rnd_rsp_zero", bus.rsp_zero, e_zero);
                chk("rnd_rsp_ovf", bus.rsp_ovf, e_ovf);
                chk("rnd_rsp_err", bus.rsp_err, e_err);
            end
            exp_exec = m_busy && !e_err && (cyc == m_exec_cyc);
            chk("rnd_alu_sel", bus.alu_sel, exp_exec ? e_sel : 3'd0);
            chk("rnd_alu_a", bus.alu_a, exp_exec ? e_a : 32'd0);
            chk("rnd_alu_b", bus.alu_b, exp_exec ? e_b : 32'd0);
            if (exp_vld && bus.rsp_ready) begin
                m_busy = 1'b0;
                if (e_err) m_cnte++;
                else if (e_id) m_cnt1++;
                else m_cnt0++;
            end
            if (g >= 0) begin
                ref_op(p_f[g], p_a[g], p_b[g], e_err, e_res, e_zero, e_ovf, e_sel);
                e_id = g[0];
                e_a = p_a[g];
                e_b = p_b[g];
                m_busy = 1'b1;
                m_exec_cyc = cyc + 1;
                m_rsp_cyc = cyc + (e_err ? 1 : 2);
                last = g;
                p_vld[g] = 1'b0;
            end
        end
        @(negedge clk);
        #1;
        chk("rnd_stat_cnt0", stat_cnt0, STATS ? m_cnt0[STAT_W-1:0] : 16'd0);
        chk("rnd_stat_cnt1", stat_cnt1, STATS ? m_cnt1[STAT_W-1:0] : 16'd0);
        chk("rnd_stat_err", stat_err, STATS ? m_cnte[STAT_W-1:0] : 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 32-bit ALU between two requesters, e.g. two R-type issue paths.
- Accepts MIPS R-type funct plus two operands per requester and arbitrates round-robin.
- Decodes funct to the 3-bit ALU select, drives the ALU from registered operands, captures result and flags, and returns a response with a valid/ready handshake.
- Sits between the R-type decode stage and the ALU; the ALU stays external.

Parameters:
DATA_W, 32, operand/result width (only 32 supported)
STAT_W, 16, width of statistics counters (optional feature only)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
req0_valid  in  1  requester 0 has an op
req0_ready  out  1  requester 0 op accepted this cycle
req0_funct  in  6  requester 0 MIPS funct
req0_a  in  32  requester 0 operand A
req0_b  in  32  requester 0 operand B (shift amount for SLL/SRL)
req1_valid, req1_ready, req1_funct, req1_a, req1_b: same as requester 0, for requester 1
alu_sel  out  3  ALU select
alu_a  out  32  ALU operand A
alu_b  out  32  ALU operand B
alu_res  in  32  ALU result
alu_zero  in  1  ALU zero flag
alu_ovf  in  1  ALU overflow, add-rule
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester that owns the response
rsp_res  out  32  captured result
rsp_zero  out  1  captured zero flag
rsp_ovf  out  1  corrected overflow
rsp_err  out  1  illegal funct
busy  out  1  state != IDLE
stat_cnt0, stat_cnt1  out  STAT_W  completed ops per requester (optional)
stat_err  out  STAT_W  illegal-op count (optional)

Behaviour:
- Reset, synchronous on rst_n=0: state=IDLE, rr_ptr=0, all rsp_* and alu_* outputs=0, busy=0, req*_ready=0. A reset mid-operation discards the in-flight op; no response is produced.

Funct to alu_sel:
- 0x24 AND → 000; 0x25 OR → 001; 0x20 ADD → 010; 0x26 XOR → 011
- 0x22 SUB → 100; 0x02 SRL → 101; 0x00 SLL → 110; 0x27 NOR → 111
- Any other funct is illegal.

FSM:
- IDLE, no valid request: stay in IDLE.
- IDLE, one valid request: grant it.
- IDLE, both valid: grant requester rr_ptr.
- On grant: reqN_ready=1 for exactly that cycle (combinational from state and valids). Register funct-decoded sel, a, b and id. rr_ptr <= ~granted id.
  - Legal op: go to EXEC.
  - Illegal op: go to RESP with rsp_err=1, rsp_res=0, flags=0.
- EXEC (1 cycle): alu_sel/alu_a/alu_b driven from registers; alu_* are 0 in all other states. Capture rsp_res=alu_res, rsp_zero=alu_zero, rsp_ovf (below), rsp_err=0. Go to RESP.
- RESP: rsp_valid=1. rsp_* stay stable until rsp_valid && rsp_ready, then go to IDLE and clear rsp_valid. No new grant in the handshake cycle.

Timing:
- Legal-op latency: grant at cycle T, rsp_valid at T+2.
- Illegal-op latency: rsp_valid at T+1.
- Minimum issue interval: 3 cycles.

Overflow:
- ADD: rsp_ovf = alu_ovf.
- SUB: rsp_ovf = (a[31]!=b[31]) && (alu_res[31]!=a[31]), computed locally.
- All other ops: rsp_ovf = 0.

Other rules:
- Requests not granted stay pending; requesters must hold valid and payload stable until ready.
- busy=1 in EXEC and RESP.

Optional Feature:
ALU_SHARE_ARBITER_STATS_EN
- Defined:
  - stat_cnt0/stat_cnt1 increment on each legal-op response handshake for that requester.
  - stat_err increments on each illegal-op handshake.
  - All counters wrap modulo 2^STAT_W and reset to 0.
- Undefined: no counter logic; stat_* tied to 0.

Test Plan:
- Single op: req0 ADD a=0x7FFFFFFF b=1, rsp_ready=1 → rsp_valid 2 cycles after grant, rsp_res=0x80000000, rsp_ovf=1, rsp_zero=0, rsp_id=0.
- SUB correction: req1 SUB a=0x80000000 b=1, alu_ovf=0 from ALU → rsp_res=0x7FFFFFFF, rsp_ovf=1. SUB a=5 b=5 → rsp_res=0, rsp_zero=1, rsp_ovf=0.
- Round robin: both requesters valid continuously with AND ops → grants alternate 0,1,0,1; each grant 3 cycles apart; ready pulses one cycle each.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_* stable, no new grant, req1_ready=0; rsp_ready=1 → IDLE next cycle, grant on the following cycle.
- Illegal funct 0x3F on req0 → rsp_err=1, rsp_res=0 one cycle after grant; alu_sel stays 000. With ALU_SHARE_ARBITER_STATS_EN: stat_err=1, stat_cnt0=0.
- Reset mid-EXEC: rst_n=0 for 1 cycle → next cycle state IDLE, rsp_valid=0, rr_ptr=0; no response issued for the dropped op.
